// File: rtl/sfla40_16x8bw16_pkg.sv
// Shared defaults and operation decode for the 16x8 binary CAM macro.
// Strobes are reduced to a single operation with FLUSH > WR > RD > CMP priority.
package sfla40_16x8bw16_pkg;

  localparam int DEF_WORDS  = 16;
  localparam int DEF_BITS   = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_BANKS  = 1;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_FLUSH,
    OP_WR,
    OP_RD,
    OP_CMP
  } op_e;

  // Lower-priority strobes asserted together with a higher one are dropped.
  function automatic op_e op_decode(input logic cs, input logic flush,
                                    input logic wr, input logic rd,
                                    input logic cmp);
    op_e op;
    op = OP_NOP;
    if (cs) begin
      if (flush)    op = OP_FLUSH;
      else if (wr)  op = OP_WR;
      else if (rd)  op = OP_RD;
      else if (cmp) op = OP_CMP;
    end
    return op;
  endfunction

endpackage

// File: rtl/sfla40_16x8bw16_row.sv
// One CAM word: data storage, valid bit and masked-compare match term.
// Data is never reset; only the valid bit is cleared by reset or flush.
import sfla40_16x8bw16_pkg::*;

module sfla40_16x8bw16_row #(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            we,
  input  logic            wr_dcs,
  input  logic            wr_vbe,
  input  logic [BITS-1:0] wr_data,
  input  logic [BITS-1:0] wr_mask,
  input  logic            wr_vbi,
  input  logic [BITS-1:0] key,
  input  logic [BITS-1:0] key_mask,
  input  logic            bank_dis,
  output logic [BITS-1:0] data,
  output logic            valid,
  output logic            match
);

  logic [BITS-1:0] data_q, data_d;
  logic            valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (we) begin
      if (wr_dcs) data_d = (data_q & ~wr_mask) | (wr_data & wr_mask);
      if (wr_vbe) valid_d = wr_vbi;
    end
  end

  always_ff @(posedge clk) data_q <= data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign match = valid_q & ~(|((data_q ^ key) & key_mask)) & ~bank_dis;

endmodule

// File: rtl/sfla40_16x8bw16.sv
// 16x8 binary CAM: masked write, read, masked compare with per-word hit
// vector, single-cycle flush. All outputs are registered and hold when idle.
import sfla40_16x8bw16_pkg::*;

module sfla40_16x8bw16 #(
  parameter int WORDS  = DEF_WORDS,
  parameter int BITS   = DEF_BITS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BANKS  = DEF_BANKS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CS,
  input  logic              FLUSH,
  input  logic              VBE,
  input  logic              DCS,
  input  logic              WR,
  input  logic              RD,
  input  logic              CMP,
  input  logic [BITS-1:0]   DI,
  input  logic [BITS-1:0]   MSKB,
  input  logic              VBI,
  input  logic [ADDR_W-1:0] A,
  input  logic [BANKS-1:0]  CBE,
  output logic [BITS-1:0]   DO,
  output logic              VBO,
  output logic              HIT,
  output logic [WORDS-1:0]  HITLINE
);

  op_e                         op;
  logic                        a_ok;
  logic [WORDS-1:0]            row_we;
  logic [WORDS-1:0][BITS-1:0]  row_data;
  logic [WORDS-1:0]            row_valid;
  logic [WORDS-1:0]            row_match;

  logic [BITS-1:0]  do_q, do_d;
  logic             vbo_q, vbo_d;
  logic             hit_q, hit_d;
  logic [WORDS-1:0] hitline_q, hitline_d;

  assign op   = op_decode(CS, FLUSH, WR, RD, CMP);
  assign a_ok = ({1'b0, A} < (ADDR_W+1)'(WORDS));

  // Reset gates writes so a write strobe during reset leaves data untouched.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_row
      localparam int BK = (gi * BANKS) / WORDS;
      assign row_we[gi] = rst_n && (op == OP_WR) && a_ok && (A == ADDR_W'(gi));
      sfla40_16x8bw16_row #(.BITS(BITS)) u_row (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (op == OP_FLUSH),
        .we       (row_we[gi]),
        .wr_dcs   (DCS),
        .wr_vbe   (VBE),
        .wr_data  (DI),
        .wr_mask  (MSKB),
        .wr_vbi   (VBI),
        .key      (DI),
        .key_mask (MSKB),
        .bank_dis (CBE[BK]),
        .data     (row_data[gi]),
        .valid    (row_valid[gi]),
        .match    (row_match[gi])
      );
    end
  endgenerate

  always_comb begin
    do_d      = do_q;
    vbo_d     = vbo_q;
    hit_d     = hit_q;
    hitline_d = hitline_q;
    case (op)
      OP_RD: begin
        if (DCS) do_d  = a_ok ? row_data[A]  : '0;
        if (VBE) vbo_d = a_ok ? row_valid[A] : 1'b0;
      end
      OP_CMP: begin
        hitline_d = row_match;
        hit_d     = |row_match;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      do_q      <= '0;
      vbo_q     <= 1'b0;
      hit_q     <= 1'b0;
      hitline_q <= '0;
    end else begin
      do_q      <= do_d;
      vbo_q     <= vbo_d;
      hit_q     <= hit_d;
      hitline_q <= hitline_d;
    end
  end

  assign DO      = do_q;
  assign VBO     = vbo_q;
  assign HIT     = hit_q;
  assign HITLINE = hitline_q;

endmodule

// File: tb/tb_sfla40_16x8bw16.sv
// Directed bench for the 16x8 CAM: driver queues hand-computed expected
// outputs, a negedge monitor pops and compares them one cycle after each op.
module tb_sfla40_16x8bw16;

  logic        clk = 1'b0;
  logic        rst_n, CS, FLUSH, VBE, DCS, WR, RD, CMP, VBI;
  logic [7:0]  DI, MSKB;
  logic [3:0]  A;
  logic [0:0]  CBE;
  logic [7:0]  DO;
  logic        VBO, HIT;
  logic [15:0] HITLINE;

  typedef struct {
    int          cyc;
    logic [7:0]  e_do;
    logic        e_vbo;
    logic        e_hit;
    logic [15:0] e_hl;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  sfla40_16x8bw16 dut (
    .clk(clk), .rst_n(rst_n), .CS(CS), .FLUSH(FLUSH), .VBE(VBE), .DCS(DCS),
    .WR(WR), .RD(RD), .CMP(CMP), .DI(DI), .MSKB(MSKB), .VBI(VBI), .A(A),
    .CBE(CBE), .DO(DO), .VBO(VBO), .HIT(HIT), .HITLINE(HITLINE)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Monitor: outputs are checked on the negedge following the op's edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else if (DO !== e.e_do || VBO !== e.e_vbo || HIT !== e.e_hit || HITLINE !== e.e_hl) begin
        failures++;
        $display("FAIL %s: got DO=%h VBO=%b HIT=%b HITLINE=%h, want DO=%h VBO=%b HIT=%b HITLINE=%h",
                 e.name, DO, VBO, HIT, HITLINE, e.e_do, e.e_vbo, e.e_hit, e.e_hl);
      end
    end
  end

  task automatic op(input string nm, input logic rst, input logic cs,
                    input logic fl, input logic wr, input logic rd, input logic cmp,
                    input logic dcs, input logic vbe, input logic vbi,
                    input logic [3:0] a, input logic [7:0] di, input logic [7:0] mskb,
                    input logic cbe, input logic [7:0] edo, input logic evbo,
                    input logic ehit, input logic [15:0] ehl);
    exp_t e;
    @(negedge clk);
    rst_n = rst; CS = cs; FLUSH = fl; WR = wr; RD = rd; CMP = cmp;
    DCS = dcs; VBE = vbe; VBI = vbi; A = a; DI = di; MSKB = mskb; CBE[0] = cbe;
    e.cyc = cyc + 1; e.e_do = edo; e.e_vbo = evbo; e.e_hit = ehit; e.e_hl = ehl; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; CS = 1'b0; FLUSH = 1'b0; WR = 1'b0; RD = 1'b0; CMP = 1'b0;
    DCS = 1'b0; VBE = 1'b0; VBI = 1'b0; A = '0; DI = '0; MSKB = '0; CBE = '0;

    //   name          rst cs fl wr rd cm dcs vbe vbi a   di     mskb   cbe  DO     VBO HIT HITLINE
    op("reset0",       0,  0, 0, 0, 0, 0, 0,  0,  0,  0, 8'h00, 8'h00, 0,   8'h00, 0,  0,  16'h0000);
    op("reset1",       0,  0, 0, 0, 0, 0, 0,  0,  0,  0, 8'h00, 8'h00, 0,   8'h00, 0,  0,  16'h0000);
    op("wr3",          1,  1, 0, 1, 0, 0, 1,  1,  1,  3, 8'hA5, 8'hFF, 0,   8'h00, 0,  0,  16'h0000);
    op("rd3",          1,  1, 0, 0, 1, 0, 1,  1,  0,  3, 8'h00, 8'h00, 0,   8'hA5, 1,  0,  16'h0000);
    op("cmp_hi_nib",   1,  1, 0, 0, 0, 1, 0,  0,  0,  0, 8'hA0, 8'hF0, 0,   8'hA5, 1,  1,  16'h0008);
    op("cmp_cbe",      1,  1, 0, 0, 0, 1, 0,  0,  0,  0, 8'hA0, 8'hF0, 1,   8'hA5, 1,  0,  16'h0000);
    op("bitwr3",       1,  1, 0, 1, 0, 0, 1,  0,  0,  3, 8'h3C, 8'h0F, 0,   8'hA5, 1,  0,  16'h0000);
    op("rd3_bitwr",    1,  1, 0, 0, 1, 0, 1,  1,  0,  3, 8'h00, 8'h00, 0,   8'hAC, 1,  0,  16'h0000);
    op("wr7",          1,  1, 0, 1, 0, 0, 1,  1,  1,  7, 8'hAC, 8'hFF, 0,   8'hAC, 1,  0,  16'h0000);
    op("cmp_multi",    1,  1, 0, 0, 0, 1, 0,  0,  0,  0, 8'hAC, 8'hFF, 0,   8'hAC, 1,  1,  16'h0088);
    op("cmp_mask0",    1,  1, 0, 0, 0, 1, 0,  0,  0,  0, 8'h00, 8'h00, 0,   8'hAC, 1,  1,  16'h0088);
    op("flush_w_cmp",  1,  1, 1, 0, 0, 1, 0,  0,  0,  0, 8'hAC, 8'hFF, 0,   8'hAC, 1,  1,  16'h0088);
    op("cmp_flushed",  1,  1, 0, 0, 0, 1, 0,  0,  0,  0, 8'hAC, 8'hFF, 0,   8'hAC, 1,  0,  16'h0000);
    op("rd3_flushed",  1,  1, 0, 0, 1, 0, 1,  1,  0,  3, 8'h00, 8'h00, 0,   8'hAC, 0,  0,  16'h0000);
    op("cs0_wr5",      1,  0, 0, 1, 0, 0, 1,  1,  1,  5, 8'h55, 8'hFF, 0,   8'hAC, 0,  0,  16'h0000);
    op("rd5_vbe",      1,  1, 0, 0, 1, 0, 0,  1,  0,  5, 8'h00, 8'h00, 0,   8'hAC, 0,  0,  16'h0000);
    op("wr5_over_rd",  1,  1, 0, 1, 1, 0, 1,  1,  1,  5, 8'h5A, 8'hFF, 0,   8'hAC, 0,  0,  16'h0000);
    op("rd5_raw",      1,  1, 0, 0, 1, 0, 1,  1,  0,  5, 8'h00, 8'h00, 0,   8'h5A, 1,  0,  16'h0000);
    op("wr6",          1,  1, 0, 1, 0, 0, 1,  1,  1,  6, 8'h66, 8'hFF, 0,   8'h5A, 1,  0,  16'h0000);
    op("cmp_after_wr", 1,  1, 0, 0, 0, 1, 0,  0,  0,  0, 8'h66, 8'hFF, 0,   8'h5A, 1,  1,  16'h0040);
    op("inval5",       1,  1, 0, 1, 0, 0, 0,  1,  0,  5, 8'hFF, 8'hFF, 0,   8'h5A, 1,  1,  16'h0040);
    op("cmp_mask0_b",  1,  1, 0, 0, 0, 1, 0,  0,  0,  0, 8'h00, 8'h00, 0,   8'h5A, 1,  1,  16'h0040);
    op("rd5_vbe_only", 1,  1, 0, 0, 1, 0, 0,  1,  0,  5, 8'h00, 8'h00, 0,   8'h5A, 0,  1,  16'h0040);
    op("cs0_cmp",      1,  0, 0, 0, 0, 1, 0,  0,  0,  0, 8'h00, 8'h00, 1,   8'h5A, 0,  1,  16'h0040);
    op("rst_mid_cmp",  0,  1, 0, 0, 0, 1, 0,  0,  0,  0, 8'h66, 8'hFF, 0,   8'h00, 0,  0,  16'h0000);
    op("cmp_post_rst", 1,  1, 0, 0, 0, 1, 0,  0,  0,  0, 8'h00, 8'h00, 0,   8'h00, 0,  0,  16'h0000);
    op("rd3_post_rst", 1,  1, 0, 0, 1, 0, 1,  1,  0,  3, 8'h00, 8'h00, 0,   8'hAC, 0,  0,  16'h0000);

    @(negedge clk);
    CS = 1'b0; WR = 1'b0; RD = 1'b0; CMP = 1'b0; FLUSH = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected responses never compared, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfla40_16x8bw16.md
Name: sfla40_16x8bw16

Overview:
- Synchronous binary CAM macro: 16 words x 8 bits, one valid bit per word.
- Supports per-bit-masked write, read, masked compare with a per-word hit vector, and single-cycle flush.
- Used by the packet-routing memory wrapper: a compare on the packet ID produces HITLINE; the wrapper encodes it into an address and reads the matching entry.

Parameters:
- WORDS, 16, number of entries.
- BITS, 8, data width per entry.
- ADDR_W, 4, address width (clog2 of WORDS).
- BANKS, 1, number of compare banks; width of CBE.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- CS  in  1  chip select; when 0, no operation executes and all outputs hold.
- FLUSH  in  1  invalidate all entries.
- VBE  in  1  valid-bit enable for write/read.
- DCS  in  1  data-array select for write/read.
- WR  in  1  write strobe.
- RD  in  1  read strobe.
- CMP  in  1  compare strobe.
- DI  in  BITS  write data / search key.
- MSKB  in  BITS  bit-write enable (write) / search mask, 1 = bit compared (compare).
- VBI  in  1  valid bit to write.
- A  in  ADDR_W  word address for read/write.
- CBE  in  BANKS  per-bank compare disable, 1 = bank excluded.
- DO  out  BITS  registered read data.
- VBO  out  1  registered read valid bit.
- HIT  out  1  registered OR of HITLINE.
- HITLINE  out  WORDS  registered per-word match vector; bit i = word i.

Behaviour:
- Storage: data[WORDS][BITS] (not reset) and valid[WORDS] (reset to 0).
- Reset: rst_n=0 at an edge sets valid=0, DO=0, VBO=0, HIT=0, HITLINE=0.
  - Reset overrides any operation in the same cycle, including a mid-sequence compare or read.
- Ops are sampled only when CS=1.
- One op per cycle, priority FLUSH > WR > RD > CMP; lower-priority strobes in the same cycle are ignored.
- FLUSH: valid[all]=0 at the edge. DO, VBO, HIT and HITLINE hold. Data array unchanged.
- WR, per bit b:
  - If DCS: data[A][b] = MSKB[b] ? DI[b] : old value.
  - If VBE: valid[A] = VBI.
  - Outputs hold.
  - WR with DCS=VBE=0 is a no-op.
- RD (1-cycle latency: outputs update at the sampling edge, valid for the following cycle):
  - If DCS: DO = data[A]; otherwise DO holds.
  - If VBE: VBO = valid[A]; otherwise VBO holds.
  - HIT and HITLINE hold.
- CMP:
  - HITLINE[i] = valid[i] & (((data[i] ^ DI) & MSKB) == 0) & ~CBE[bank(i)].
  - Single bank: bank(i) = 0.
  - HIT = |HITLINE.
  - Both registered at the sampling edge; held until the next CMP or reset.
  - DO and VBO hold.
  - MSKB=0 matches every valid word.
  - An invalid word never hits.
  - Multiple hits are all reported; no priority encoding inside the block.
- Address A >= WORDS (non-power-of-2 configs only): write ignored; read returns DO=0, VBO=0.
- Read-after-write to the same address in the next cycle returns the new data.
- Compare in the cycle after a write sees the updated entry.
- CS=0: no state change; all outputs hold their last values.

Decomposition:
- Shared package: parameter defaults (WORDS, BITS, ADDR_W, BANKS).
- Natural sub-module: cam_match_row, one storage word plus its valid bit and masked-compare logic. Instantiate WORDS times; the top handles write decode, read mux, flush and output registers.

Test Plan:
- Write A=3, DI=0xA5, MSKB=0xFF, DCS=1, VBE=1, VBI=1; then RD A=3 with DCS=VBE=1 -> next cycle DO=0xA5, VBO=1.
- CMP with DI=0xA0, MSKB=0xF0, CBE=0 -> HITLINE=0x0008, HIT=1.
- Same CMP with CBE=1 -> HITLINE=0x0000, HIT=0.
- Bit-write A=3, DI=0x3C, MSKB=0x0F, DCS=1, VBE=0 -> RD A=3 gives DO=0xAC, VBO=1.
- Write A=7 with the same data 0xAC, then CMP DI=0xAC, MSKB=0xFF -> HITLINE=0x0088, HIT=1.
- FLUSH, then the same compare -> HITLINE=0, HIT=0; RD A=3 -> VBO=0, DO=0xAC.
- CS=0 with WR=1 to A=5 -> RD A=5 gives VBO=0.
- rst_n=0 during a CMP cycle -> HIT=0, HITLINE=0, DO=0, VBO=0 after the edge; all entries invalid.
